// File: rtl/flit_rx_unpacker_if.sv
// Flit link and word port of the receive-side unpacker.
// The slave side is the unpacker; the master side is the flit source and word consumer.
interface flit_rx_unpacker_if;
  logic [127:0] flit_rx;
  logic         flit_rx_vld;
  logic [31:0]  data_out;
  logic         data_out_vld;
  logic         data_out_rdy;

  modport slave (
    input  flit_rx,
    input  flit_rx_vld,
    input  data_out_rdy,
    output data_out,
    output data_out_vld
  );

  modport master (
    output flit_rx,
    output flit_rx_vld,
    output data_out_rdy,
    input  data_out,
    input  data_out_vld
  );
endinterface

// File: rtl/flit_rx_unpacker.sv
// Buffers 128-bit flits from a non-stalling link in a small FIFO and serialises
// each one into four 32-bit words, low word first, on a valid/ready port.
module flit_rx_unpacker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flit_rx_unpacker_if.slave    link,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [127:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       word_idx;
  logic [LVL_W-1:0] count;
  logic [127:0]     head;

  logic not_empty;
  logic is_full;
  logic xfer;
  logic pop;
  logic push;
  logic drop;

  assign not_empty = (count != '0);
  assign is_full   = (count == FULL_LVL);
  assign xfer      = not_empty && link.data_out_rdy;
  assign pop       = xfer && (word_idx == 2'd3);
  // A full FIFO still accepts a flit when the final word of the head leaves this cycle.
  assign push      = link.flit_rx_vld && (!is_full || pop);
  assign drop      = link.flit_rx_vld && is_full && !pop;

  assign link.data_out_vld = not_empty;
  assign fifo_level        = count;

  always_comb begin
    head          = mem[rd_ptr];
    link.data_out = head[31:0];
    case (word_idx)
      2'd0: link.data_out = head[31:0];
      2'd1: link.data_out = head[63:32];
      2'd2: link.data_out = head[95:64];
      2'd3: link.data_out = head[127:96];
      default: link.data_out = head[31:0];
    endcase
  end

  // Payload storage carries no reset; it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= link.flit_rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_idx <= 2'd0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (xfer) begin
        word_idx <= word_idx + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_rx_unpacker.sv
// Scoreboard bench for flit_rx_unpacker: expected words are queued as flits are
// driven and popped by a negedge monitor whenever a word transfer is about to occur.
module tb_flit_rx_unpacker;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic [2:0]       fifo_level;

  flit_rx_unpacker_if dut_if ();

  flit_rx_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link       (dut_if.slave),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];

  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] exp_w;

  // Drive one cycle of inputs at posedge+1, then advance to the next posedge+1.
  task automatic step(input logic v, input logic [127:0] f, input logic r);
    dut_if.flit_rx_vld  = v;
    dut_if.flit_rx      = f;
    dut_if.data_out_rdy = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic expect_flit(input logic [127:0] f);
    for (int i = 0; i < 4; i++) sb.push_back(f[32*i +: 32]);
  endtask

  // Monitor: word order against the scoreboard and hold stability under backpressure.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        checks++;
        if (dut_if.data_out_vld !== 1'b1 || dut_if.data_out !== prev_data) begin
          errors++;
          $display("[TB] FAIL hold: vld=%b data=%h required vld=1 data=%h",
                   dut_if.data_out_vld, dut_if.data_out, prev_data);
        end
      end
      if (dut_if.data_out_vld === 1'b1 && dut_if.data_out_rdy === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL word_unexpected: got %h with empty scoreboard", dut_if.data_out);
        end else begin
          exp_w = sb.pop_front();
          if (dut_if.data_out !== exp_w) begin
            errors++;
            $display("[TB] FAIL word: got %h required %h", dut_if.data_out, exp_w);
          end
        end
      end
      prev_vld  = dut_if.data_out_vld;
      prev_rdy  = dut_if.data_out_rdy;
      prev_data = dut_if.data_out;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    dut_if.flit_rx_vld  = 1'b0;
    dut_if.flit_rx      = '0;
    dut_if.data_out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (dut_if.data_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b required 0", dut_if.data_out_vld); end
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b required 0", overflow); end
    if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
    if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d required 0", fifo_level); end
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_single();
    logic [127:0] f;
    f = 128'h44444444_33333333_22222222_11111111;
    expect_flit(f);
    step(1'b1, f, 1'b1);
    checks++;
    if (dut_if.data_out_vld !== 1'b1 || dut_if.data_out !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL single_latency: vld=%b data=%h required vld=1 data=11111111",
               dut_if.data_out_vld, dut_if.data_out);
    end
    repeat (4) step(1'b0, '0, 1'b1);
    checks += 2;
    if (dut_if.data_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_vld: got %b required 0", dut_if.data_out_vld); end
    if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL single_level: got %0d required 0", fifo_level); end
  endtask

  task automatic test_backpressure();
    logic [6:0] pattern;
    pattern = 7'b1011001;
    expect_flit(128'h44444444_33333333_22222222_11111111);
    step(1'b1, 128'h44444444_33333333_22222222_11111111, 1'b0);
    for (int i = 6; i >= 0; i--) step(1'b0, '0, pattern[i]);
    checks += 2;
    if (dut_if.data_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty_vld: got %b required 0", dut_if.data_out_vld); end
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL bp_lost: %0d words outstanding required 0", sb.size()); end
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < DEPTH) expect_flit(mk(32'h0A000000 + 32'(i) * 32'h10));
      step(1'b1, mk(32'h0A000000 + 32'(i) * 32'h10), 1'b0);
      if (overflow === 1'b1) pulses++;
    end
    step(1'b0, '0, 1'b0);
    if (overflow === 1'b1) pulses++;
    checks += 3;
    if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level: got %0d required 4", fifo_level); end
    if (pulses != 2) begin errors++; $display("[TB] FAIL ovf_pulses: got %0d required 2", pulses); end
    if (drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL ovf_drop_cnt: got %0d required 2", drop_cnt); end
    repeat (16) step(1'b0, '0, 1'b1);
    checks += 2;
    if (dut_if.data_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain_vld: got %b required 0", dut_if.data_out_vld); end
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL ovf_lost: %0d words outstanding required 0", sb.size()); end
  endtask

  task automatic test_push_full_pop();
    for (int i = 0; i < DEPTH; i++) begin
      expect_flit(mk(32'hB0000000 + 32'(i) * 32'h10));
      step(1'b1, mk(32'hB0000000 + 32'(i) * 32'h10), 1'b0);
    end
    repeat (3) step(1'b0, '0, 1'b1);
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL pfp_level_before: got %0d required 4", fifo_level); end
    expect_flit(mk(32'hBE000000));
    step(1'b1, mk(32'hBE000000), 1'b1);
    checks += 3;
    if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL pfp_level_after: got %0d required 4", fifo_level); end
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pfp_overflow: got %b required 0", overflow); end
    if (drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL pfp_drop_cnt: got %0d required 2", drop_cnt); end
    repeat (16) step(1'b0, '0, 1'b1);
    checks += 2;
    if (dut_if.data_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL pfp_drain_vld: got %b required 0", dut_if.data_out_vld); end
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL pfp_lost: %0d words outstanding required 0", sb.size()); end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_flit(mk(32'hC0000000 + 32'(i) * 32'h10));
      step(1'b1, mk(32'hC0000000 + 32'(i) * 32'h10), 1'b0);
    end
    for (int i = 0; i < 260; i++) begin
      step(1'b1, mk(32'hDD000000 + 32'(i) * 32'h10), 1'b0);
      if (overflow === 1'b1) pulses++;
    end
    checks += 2;
    if (pulses != 260) begin errors++; $display("[TB] FAIL sat_pulses: got %0d required 260", pulses); end
    if (drop_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL sat_drop_cnt: got %0d required 255", drop_cnt); end
    step(1'b0, '0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sat_overflow_end: got %b required 0", overflow); end
    repeat (16) step(1'b0, '0, 1'b1);
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL sat_lost: %0d words outstanding required 0", sb.size()); end
  endtask

  task automatic test_wrap();
    int max_level;
    max_level = 0;
    for (int i = 0; i < 10; i++) begin
      expect_flit(mk(32'hE0000000 + 32'(i) * 32'h10));
      step(1'b1, mk(32'hE0000000 + 32'(i) * 32'h10), 1'b1);
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      for (int k = 0; k < 4; k++) begin
        step(1'b0, '0, 1'b1);
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      end
    end
    checks += 2;
    if (max_level > 1) begin errors++; $display("[TB] FAIL wrap_level: max %0d required <=1", max_level); end
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL wrap_lost: %0d words outstanding required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] a;
    a = mk(32'hF0000000);
    sb.push_back(a[31:0]);
    sb.push_back(a[63:32]);
    step(1'b1, a, 1'b0);
    step(1'b1, mk(32'hF1000000), 1'b0);
    step(1'b1, mk(32'hF2000000), 1'b0);
    repeat (2) step(1'b0, '0, 1'b1);
    dut_if.data_out_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (dut_if.data_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_vld: got %b required 0", dut_if.data_out_vld); end
    if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL rst_mid_level: got %0d required 0", fifo_level); end
    if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL rst_mid_drop_cnt: got %0d required 0", drop_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_flit(mk(32'h5A000000));
    step(1'b1, mk(32'h5A000000), 1'b1);
    checks++;
    if (dut_if.data_out !== 32'h5A000000) begin errors++; $display("[TB] FAIL rst_mid_word0: got %h required 5a000000", dut_if.data_out); end
    repeat (4) step(1'b0, '0, 1'b1);
    checks += 3;
    if (dut_if.data_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_empty: got %b required 0", dut_if.data_out_vld); end
    if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL rst_mid_drop_end: got %0d required 0", drop_cnt); end
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL rst_mid_lost: %0d words outstanding required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_push_full_pop();
    test_saturation();
    test_wrap();
    test_reset_mid();
    repeat (2) step(1'b0, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
